ddr_native_rw_arbiter: RTL and testbench

//  Shares one DDR-IP native app port between a write requester and a read requester.

---
 rtl/ddr_native_rw_arbiter.sv | 147 ++++++++++++++
 tb/tb_ddr_native_rw_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_native_rw_arbiter.sv
// ddr_native_rw_arbiter: shares one MIG-style native app port between a write and a read requester.
// Ports:
//   axi_aclk, axi_areset            clock, asynchronous active-high reset
//   init_calib_complete             DDR IP calibration done; no grants while low
//   wr_req_valid/addr/data/mask     write request in, wr_req_ready pulses when captured
//   rd_req_valid/addr               read request in, rd_req_ready pulses when captured
//   rd_data, rd_data_valid          app_rd_data / app_rd_data_valid registered by one cycle
//   app_addr/cmd/en                 native command out, handshaken by app_rdy
//   app_wdf_data/mask/wren/end      native write data out, handshaken by app_wdf_rdy
//   app_rd_data/valid/end           native read return in
//   rd_outstanding                  reads issued but not yet returned
module ddr_native_rw_arbiter #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_BURST       = 8,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                               axi_aclk,
    input  logic                               axi_areset,
    input  logic                               init_calib_complete,
    input  logic                               wr_req_valid,
    input  logic [ADDR_WIDTH-1:0]              wr_req_addr,
    input  logic [DATA_WIDTH-1:0]              wr_req_data,
    input  logic [DATA_WIDTH/8-1:0]            wr_req_mask,
    output logic                               wr_req_ready,
    input  logic                               rd_req_valid,
    input  logic [ADDR_WIDTH-1:0]              rd_req_addr,
    output logic                               rd_req_ready,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_data_valid,
    output logic [ADDR_WIDTH-1:0]              app_addr,
    output logic [2:0]                         app_cmd,
    output logic                               app_en,
    output logic [DATA_WIDTH-1:0]              app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]            app_wdf_mask,
    output logic                               app_wdf_wren,
    output logic                               app_wdf_end,
    input  logic                               app_rdy,
    input  logic                               app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]              app_rd_data,
    input  logic                               app_rd_data_valid,
    input  logic                               app_rd_data_end,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int MW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {CALIB, IDLE, WR, RD} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic                   last_dir_q, last_dir_d;
    logic                   app_en_q, app_en_d;
    logic [2:0]             app_cmd_q, app_cmd_d;
    logic [ADDR_WIDTH-1:0]  app_addr_q, app_addr_d;
    logic [DATA_WIDTH-1:0]  wdf_data_q, wdf_data_d;
    logic [MW-1:0]          wdf_mask_q, wdf_mask_d;
    logic                   wdf_wren_q, wdf_wren_d;
    logic [OW-1:0]          rd_out_q, rd_out_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   rd_data_valid_q, rd_data_valid_d;

    logic                   cmd_hs, rd_issue, retire, can_grant, rd_ok, grant, grant_dir, tie_dir;
    logic [OW:0]            rd_eff;
    logic                   unused_rd_data_end;

    assign unused_rd_data_end = app_rd_data_end;

    // Direction bit: 0 = write, 1 = read; also the low bit of app_cmd.
    always_comb begin
        cmd_hs    = app_en_q & app_rdy;
        rd_issue  = cmd_hs & app_cmd_q[0];
        // The read retiring this cycle already counts against the in-flight cap.
        rd_eff    = {1'b0, rd_out_q} + (OW + 1)'(rd_issue);
        retire    = (state_q == WR) ? (~app_en_q | app_rdy) & (~wdf_wren_q | app_wdf_rdy) :
                    (state_q == RD) ? (~app_en_q | app_rdy) : 1'b0;
        can_grant = init_calib_complete & ((state_q == IDLE) | retire);
        rd_ok     = rd_req_valid & (rd_eff < (OW + 1)'(MAX_OUTSTANDING));
        // While busy, last_dir_q is the current direction, so one rule covers both cases.
        tie_dir   = ((state_q == IDLE) | (burst_cnt_q >= BW'(MAX_BURST))) ? ~last_dir_q : last_dir_q;
        grant     = can_grant & (wr_req_valid | rd_ok);
        grant_dir = (wr_req_valid & rd_ok) ? tie_dir : rd_ok;
        wr_req_ready = grant & ~grant_dir;
        rd_req_ready = grant & grant_dir;
        burst_cnt_d = ~grant ? burst_cnt_q :
                      (grant_dir != last_dir_q) ? BW'(1) :
                      (burst_cnt_q < BW'(MAX_BURST)) ? burst_cnt_q + BW'(1) : burst_cnt_q;
        last_dir_d  = grant ? grant_dir : last_dir_q;
        app_en_d    = grant | (app_en_q & ~app_rdy);
        app_cmd_d   = grant ? {2'b00, grant_dir} : app_cmd_q;
        app_addr_d  = grant ? (grant_dir ? rd_req_addr : wr_req_addr) : app_addr_q;
        wdf_wren_d  = (grant & ~grant_dir) | (wdf_wren_q & ~app_wdf_rdy);
        wdf_data_d  = (grant & ~grant_dir) ? wr_req_data : wdf_data_q;
        wdf_mask_d  = (grant & ~grant_dir) ? wr_req_mask : wdf_mask_q;
        rd_out_d    = (rd_issue & ~app_rd_data_valid) ? rd_out_q + OW'(1) :
                      (~rd_issue & app_rd_data_valid & (|rd_out_q)) ? rd_out_q - OW'(1) : rd_out_q;
        rd_data_d       = app_rd_data;
        rd_data_valid_d = app_rd_data_valid;
        // A busy state holds until its command retires; calibration loss only lands on CALIB
        // once nothing is in progress.
        state_d = grant ? (grant_dir ? RD : WR) :
                  (((state_q == WR) | (state_q == RD)) & ~retire) ? state_q :
                  init_calib_complete ? IDLE : CALIB;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q         <= CALIB;
            burst_cnt_q     <= '0;
            last_dir_q      <= 1'b1;
            app_en_q        <= 1'b0;
            app_cmd_q       <= '0;
            app_addr_q      <= '0;
            wdf_data_q      <= '0;
            wdf_mask_q      <= '0;
            wdf_wren_q      <= 1'b0;
            rd_out_q        <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_cnt_q     <= burst_cnt_d;
            last_dir_q      <= last_dir_d;
            app_en_q        <= app_en_d;
            app_cmd_q       <= app_cmd_d;
            app_addr_q      <= app_addr_d;
            wdf_data_q      <= wdf_data_d;
            wdf_mask_q      <= wdf_mask_d;
            wdf_wren_q      <= wdf_wren_d;
            rd_out_q        <= rd_out_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    assign app_en         = app_en_q;
    assign app_cmd        = app_cmd_q;
    assign app_addr       = app_addr_q;
    assign app_wdf_data   = wdf_data_q;
    assign app_wdf_mask   = wdf_mask_q;
    assign app_wdf_wren   = wdf_wren_q;
    assign app_wdf_end    = wdf_wren_q;
    assign rd_outstanding = rd_out_q;
    assign rd_data        = rd_data_q;
    assign rd_data_valid  = rd_data_valid_q;
endmodule

// File: tb/tb_ddr_native_rw_arbiter.sv
// tb_ddr_native_rw_arbiter: randomized scenario bench for ddr_native_rw_arbiter
module tb_ddr_native_rw_arbiter;
    localparam int AW = 27;
    localparam int DW = 256;
    localparam int MW = DW / 8;
    localparam int MB = 8;
    localparam int MO = 32;
    localparam int OW = $clog2(MO) + 1;

    logic axi_aclk = 1'b0;
    logic axi_areset, init_calib_complete;
    logic wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
    logic [AW-1:0] wr_req_addr, rd_req_addr, app_addr;
    logic [DW-1:0] wr_req_data, rd_data, app_wdf_data, app_rd_data;
    logic [MW-1:0] wr_req_mask, app_wdf_mask;
    logic rd_data_valid, app_en, app_wdf_wren, app_wdf_end;
    logic [2:0] app_cmd;
    logic app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic [OW-1:0] rd_outstanding;
    int passed = 0;
    int total = 0;

    always #5 axi_aclk = ~axi_aclk;

    ddr_native_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .init_calib_complete(init_calib_complete),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_mask(wr_req_mask), .wr_req_ready(wr_req_ready),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .rd_outstanding(rd_outstanding)
    );

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic randomize_fields();
        wr_req_addr = AW'($urandom());
        wr_req_data = rnd_data();
        wr_req_mask = MW'($urandom());
        rd_req_addr = AW'($urandom());
        app_rd_data = rnd_data();
    endtask

    task automatic do_reset();
        axi_areset = 1'b1;
        init_calib_complete = 1'b0;
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data_end = 1'b0;
        randomize_fields();
        repeat (2) @(negedge axi_aclk);
        axi_areset = 1'b0;
        init_calib_complete = 1'b1;
    endtask

    task automatic test_reset();
        axi_areset = 1'b1;
        init_calib_complete = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b0;
        randomize_fields();
        repeat (2) @(negedge axi_aclk);
        #1;
        total++; if (app_en !== 1'b0) $display("FAIL reset_app_en: got %b want 0", app_en); else passed++;
        total++; if ({app_wdf_wren, app_wdf_end} !== 2'b00) $display("FAIL reset_wren_end: got %b want 00", {app_wdf_wren, app_wdf_end}); else passed++;
        total++; if ({wr_req_ready, rd_req_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {wr_req_ready, rd_req_ready}); else passed++;
        total++; if ({app_cmd, app_addr} !== '0) $display("FAIL reset_cmd_addr: got %h want 0", {app_cmd, app_addr}); else passed++;
        total++; if (rd_outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", rd_outstanding); else passed++;
        total++; if (rd_data_valid !== 1'b0) $display("FAIL reset_rd_data_valid: got %b want 0", rd_data_valid); else passed++;
    endtask

    task automatic test_calib();
        int bad;
        do_reset();
        init_calib_complete = 1'b0;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge axi_aclk); randomize_fields(); #1;
            if (wr_req_ready | rd_req_ready | app_en) bad++;
        end
        total++; if (bad !== 0) $display("FAIL calib_low_quiet: got %0d active cycles want 0", bad); else passed++;
        @(negedge axi_aclk); init_calib_complete = 1'b1; app_rdy = 1'b0; #1;
        total++; if ({wr_req_ready, rd_req_ready} !== 2'b00) $display("FAIL calib_rise_same_cycle: got %b want 00", {wr_req_ready, rd_req_ready}); else passed++;
        @(negedge axi_aclk); #1;
        total++; if ({wr_req_ready, rd_req_ready} !== 2'b10) $display("FAIL calib_first_grant: got %b want 10", {wr_req_ready, rd_req_ready}); else passed++;
        // Drop calibration while the write command is still waiting for app_rdy.
        @(negedge axi_aclk); init_calib_complete = 1'b0; #1;
        total++; if (app_en !== 1'b1) $display("FAIL calib_drop_pending: got %b want 1", app_en); else passed++;
        bad = 0;
        repeat (5) begin
            @(negedge axi_aclk); #1;
            if (wr_req_ready | rd_req_ready | !app_en) bad++;
        end
        app_rdy = 1'b1;
        repeat (11) begin
            @(negedge axi_aclk); #1;
            if (wr_req_ready | rd_req_ready) bad++;
        end
        total++; if (bad !== 0) $display("FAIL calib_drop_finish: got %0d bad cycles want 0", bad); else passed++;
        total++; if (app_en !== 1'b0) $display("FAIL calib_drop_retired: got %b want 0", app_en); else passed++;
        @(negedge axi_aclk); init_calib_complete = 1'b1; #1;
        total++; if ({wr_req_ready, rd_req_ready} !== 2'b00) $display("FAIL calib_regain_same_cycle: got %b want 00", {wr_req_ready, rd_req_ready}); else passed++;
        @(negedge axi_aclk); #1;
        total++; if ({wr_req_ready, rd_req_ready} !== 2'b01) $display("FAIL calib_tie_after_write: got %b want 01", {wr_req_ready, rd_req_ready}); else passed++;
    endtask

    // Reference: with both sides always valid and an always-ready port, grant k goes to
    // write for k/MAX_BURST even and read for k/MAX_BURST odd, one grant every clock.
    task automatic test_back_to_back();
        logic [1:0] exp;
        logic [AW+2:0] prev;
        do_reset();
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b1;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        prev = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge axi_aclk); randomize_fields(); #1;
            exp = ((k / MB) % 2 == 1) ? 2'b01 : 2'b10;
            total++; if ({wr_req_ready, rd_req_ready} !== exp) $display("FAIL b2b_grant_%0d: got %b want %b", k, {wr_req_ready, rd_req_ready}, exp); else passed++;
            if (k > 0) begin
                total++; if ({app_en, app_cmd, app_addr} !== {1'b1, prev}) $display("FAIL b2b_cmd_%0d: got %h want %h", k, {app_en, app_cmd, app_addr}, {1'b1, prev}); else passed++;
            end
            prev = {2'b00, rd_req_ready, rd_req_ready ? rd_req_addr : wr_req_addr};
        end
    endtask

    task automatic test_wdf_stall();
        int grants, en_seen, wren_seen, bad;
        logic [DW-1:0] cap;
        do_reset();
        app_rdy = 1'b1;
        grants = 0; en_seen = 0; wren_seen = 0; bad = 0; cap = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge axi_aclk);
            randomize_fields();
            wr_req_valid = (grants == 0);
            app_wdf_rdy = (wren_seen == 5);
            #1;
            if (app_en) en_seen++;
            if (app_wdf_wren) begin
                wren_seen++;
                if (app_wdf_data !== cap || app_wdf_end !== 1'b1) bad++;
            end
            if (wr_req_ready) cap = wr_req_data;
            grants += int'(wr_req_ready) + int'(rd_req_ready);
        end
        total++; if (en_seen !== 1) $display("FAIL wdf_stall_app_en: got %0d cycles want 1", en_seen); else passed++;
        total++; if (wren_seen !== 6) $display("FAIL wdf_stall_wren: got %0d cycles want 6", wren_seen); else passed++;
        total++; if (grants !== 1) $display("FAIL wdf_stall_grants: got %0d want 1", grants); else passed++;
        total++; if (bad !== 0) $display("FAIL wdf_stall_data_hold: got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_rd_cap();
        int grants;
        logic pv;
        logic [DW-1:0] pd;
        do_reset();
        app_rdy = 1'b1;
        grants = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge axi_aclk); randomize_fields(); rd_req_valid = (grants < 36); #1;
            if (rd_req_ready) grants++;
        end
        total++; if (grants !== MO) $display("FAIL rd_cap_issued: got %0d want %0d", grants, MO); else passed++;
        total++; if (rd_outstanding !== OW'(MO)) $display("FAIL rd_cap_outstanding: got %0d want %0d", rd_outstanding, MO); else passed++;
        pv = 1'b0; pd = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge axi_aclk); randomize_fields();
            rd_req_valid = (grants < 36);
            app_rd_data_valid = (c < 4);
            #1;
            total++; if (rd_data_valid !== pv || (pv && rd_data !== pd)) $display("FAIL rd_cap_data_%0d: got %b/%h want %b/%h", c, rd_data_valid, rd_data, pv, pd); else passed++;
            pv = app_rd_data_valid; pd = app_rd_data;
            if (rd_req_ready) grants++;
        end
        total++; if (grants !== 36) $display("FAIL rd_cap_resume: got %0d want 36", grants); else passed++;
        total++; if (rd_outstanding !== OW'(MO)) $display("FAIL rd_cap_final: got %0d want %0d", rd_outstanding, MO); else passed++;
    endtask

    task automatic test_same_cycle();
        int issued, mdl, both;
        logic iss, pv;
        logic [DW-1:0] pd;
        do_reset();
        app_rdy = 1'b1;
        rd_req_valid = 1'b1;
        issued = 0; mdl = 0; both = 0; pv = 1'b0; pd = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_aclk); randomize_fields();
            app_rd_data_valid = (issued >= 1) && app_en;
            #1;
            total++; if (rd_outstanding !== OW'(mdl)) $display("FAIL same_cycle_cnt_%0d: got %0d want %0d", c, rd_outstanding, mdl); else passed++;
            total++; if (rd_data_valid !== pv || (pv && rd_data !== pd)) $display("FAIL same_cycle_data_%0d: got %b/%h want %b/%h", c, rd_data_valid, rd_data, pv, pd); else passed++;
            iss = app_en && app_rdy && (app_cmd == 3'b001);
            if (iss) issued++;
            if (iss && app_rd_data_valid) both++;
            if (iss && !app_rd_data_valid) mdl++;
            else if (!iss && app_rd_data_valid && mdl > 0) mdl--;
            pv = app_rd_data_valid; pd = app_rd_data;
        end
        total++; if (rd_outstanding !== OW'(1) || both < 10) $display("FAIL same_cycle_final: got %0d (%0d overlaps) want 1", rd_outstanding, both); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        do_reset();
        wr_req_valid = 1'b1;
        @(negedge axi_aclk); #1;
        total++; if (wr_req_ready !== 1'b1) $display("FAIL mid_grant: got %b want 1", wr_req_ready); else passed++;
        @(negedge axi_aclk); #1;
        total++; if ({app_en, app_wdf_wren} !== 2'b11) $display("FAIL mid_active: got %b want 11", {app_en, app_wdf_wren}); else passed++;
        #1 axi_areset = 1'b1;
        #1;
        total++; if ({app_en, app_wdf_wren, app_wdf_end, wr_req_ready} !== 4'b0000) $display("FAIL mid_async_clear: got %b want 0000", {app_en, app_wdf_wren, app_wdf_end, wr_req_ready}); else passed++;
        d = rnd_data();
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
        #1 axi_areset = 1'b0;
        #0;
        total++; if (wr_req_ready !== 1'b0) $display("FAIL mid_state_calib: got %b want 0", wr_req_ready); else passed++;
        @(negedge axi_aclk); app_rd_data_valid = 1'b0; #1;
        total++; if (rd_data_valid !== 1'b1 || rd_data !== d) $display("FAIL mid_late_data: got %b/%h want 1/%h", rd_data_valid, rd_data, d); else passed++;
        total++; if (rd_outstanding !== '0) $display("FAIL mid_cnt_zero: got %0d want 0", rd_outstanding); else passed++;
        total++; if (wr_req_ready !== 1'b1) $display("FAIL mid_regrant: got %b want 1", wr_req_ready); else passed++;
    endtask

    // Scoreboard: each grant queues the captured request; every native command and
    // write-data handshake must present the oldest queued entry.
    task automatic test_random();
        logic [AW:0] cq[$];
        logic [DW+MW-1:0] wq[$];
        logic [AW:0] e;
        logic [DW+MW-1:0] w;
        int mdl;
        logic iss, pv;
        logic [DW-1:0] pd;
        do_reset();
        mdl = 0; pv = 1'b0; pd = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge axi_aclk);
            randomize_fields();
            wr_req_valid = (c < 470) && ($urandom_range(0, 1) == 1);
            rd_req_valid = (c < 470) && ($urandom_range(0, 1) == 1);
            app_rdy = (c >= 470) || ($urandom_range(0, 9) < 7);
            app_wdf_rdy = (c >= 470) || ($urandom_range(0, 9) < 7);
            app_rd_data_valid = ($urandom_range(0, 9) < 3);
            #1;
            total++; if (rd_data_valid !== pv || (pv && rd_data !== pd)) $display("FAIL rnd_rd_data_%0d: got %b/%h want %b/%h", c, rd_data_valid, rd_data, pv, pd); else passed++;
            total++; if (rd_outstanding !== OW'(mdl)) $display("FAIL rnd_outstanding_%0d: got %0d want %0d", c, rd_outstanding, mdl); else passed++;
            total++; if ((wr_req_ready & ~wr_req_valid) | (rd_req_ready & ~rd_req_valid) | (wr_req_ready & rd_req_ready)) $display("FAIL rnd_ready_%0d: got %b want subset of %b, one-hot", c, {wr_req_ready, rd_req_ready}, {wr_req_valid, rd_req_valid}); else passed++;
            if (app_en && app_rdy) begin
                total++;
                if (cq.size() == 0) $display("FAIL rnd_cmd_%0d: got spurious %h want none", c, {app_cmd, app_addr});
                else begin
                    e = cq.pop_front();
                    if ({app_cmd, app_addr} !== {2'b00, e}) $display("FAIL rnd_cmd_%0d: got %h want %h", c, {app_cmd, app_addr}, {2'b00, e}); else passed++;
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                total++;
                if (wq.size() == 0) $display("FAIL rnd_wdf_%0d: got spurious write data want none", c);
                else begin
                    w = wq.pop_front();
                    if ({app_wdf_end, app_wdf_data, app_wdf_mask} !== {1'b1, w}) $display("FAIL rnd_wdf_%0d: got %h want %h", c, {app_wdf_end, app_wdf_data, app_wdf_mask}, {1'b1, w}); else passed++;
                end
            end
            iss = app_en && app_rdy && (app_cmd == 3'b001);
            if (iss && !app_rd_data_valid) mdl++;
            else if (!iss && app_rd_data_valid && mdl > 0) mdl--;
            pv = app_rd_data_valid; pd = app_rd_data;
            if (wr_req_ready) begin
                cq.push_back({1'b0, wr_req_addr});
                wq.push_back({wr_req_data, wr_req_mask});
            end
            if (rd_req_ready) cq.push_back({1'b1, rd_req_addr});
        end
        total++; if (cq.size() + wq.size() !== 0) $display("FAIL rnd_drain: got %0d pending want 0", cq.size() + wq.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_calib();
        test_back_to_back();
        test_wdf_stall();
        test_rd_cap();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
